// File: rtl/traffic_pkg.sv
// Shared constants for the traffic light controller: state encoding,
// timer interval codes and the 7-bit light patterns {main RYG, side RYG, walk}.
package traffic_pkg;

    // Controller states. WALK keeps its code even when the pedestrian
    // feature is compiled out, so the encoding is identical in both builds.
    typedef enum logic [2:0] {
        ST_MG1  = 3'd0,
        ST_MG2  = 3'd1,
        ST_MY   = 3'd2,
        ST_WALK = 3'd3,
        ST_SG   = 3'd4,
        ST_SGX  = 3'd5,
        ST_SY   = 3'd6
    } state_e;

    // Interval select codes understood by the interval timer.
    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;

    // Light patterns: bit6..4 main R,Y,G; bit3..1 side R,Y,G; bit0 walk.
    localparam logic [6:0] LT_MAIN_GREEN  = 7'h18;
    localparam logic [6:0] LT_MAIN_YELLOW = 7'h28;
    localparam logic [6:0] LT_WALK        = 7'h49;
    localparam logic [6:0] LT_SIDE_GREEN  = 7'h42;
    localparam logic [6:0] LT_SIDE_YELLOW = 7'h44;

endpackage

// File: rtl/traffic_fsm.sv
// Main sequencing FSM of the traffic light controller.
// Requests timed intervals from the interval timer (interval/start_timer)
// and advances when the timer reports expired. All outputs are registered.
// Build option: define PED_WALK_EN to include the pedestrian WALK phase;
// without it MY always proceeds to SG, wr is ignored and wr_reset stays 0.
//
// Handshake with the timer: start_timer is a one-cycle pulse on the first
// cycle of every state (interval valid alongside it and held afterwards);
// expired is only acted on in cycles where start_timer is low.
module traffic_fsm
    import traffic_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sensor_sync,
    input  logic       wr,
    input  logic       prog_sync,
    input  logic       expired,
    output logic       wr_reset,
    output logic [1:0] interval,
    output logic       start_timer,
    output logic [6:0] lights,
    output logic [2:0] state_dbg_o
);

    state_e     state_q, state_d;
    logic [1:0] interval_q, interval_d;
    logic       start_q, start_d;
    logic       wr_reset_q, wr_reset_d;
    logic [6:0] lights_q, lights_d;
    logic       advance;

`ifndef PED_WALK_EN
    // The walk request is not consulted in this build.
    logic wr_unused;
    assign wr_unused = wr;
`endif

    // A timer expiry only counts once the timer has actually been restarted.
    assign advance = expired && !start_q;

    // Next-state, interval and pulse generation; prog_sync overrides everything.
    always_comb begin
        state_d    = state_q;
        interval_d = interval_q;
        start_d    = 1'b0;
        wr_reset_d = 1'b0;
        if (prog_sync) begin
            state_d    = ST_MG1;
            interval_d = INT_BASE;
            start_d    = 1'b1;
        end else begin
            case (state_q)
                ST_MG1: begin
                    if (advance) begin
                        state_d    = ST_MG2;
                        interval_d = sensor_sync ? INT_EXT : INT_BASE;
                        start_d    = 1'b1;
                    end
                end
                ST_MG2: begin
                    if (advance) begin
                        state_d    = ST_MY;
                        interval_d = INT_YEL;
                        start_d    = 1'b1;
                    end
                end
                ST_MY: begin
                    if (advance) begin
                        start_d = 1'b1;
`ifdef PED_WALK_EN
                        if (wr) begin
                            state_d    = ST_WALK;
                            interval_d = INT_EXT;
                            wr_reset_d = 1'b1;
                        end else begin
                            state_d    = ST_SG;
                            interval_d = INT_BASE;
                        end
`else
                        state_d    = ST_SG;
                        interval_d = INT_BASE;
`endif
                    end
                end
`ifdef PED_WALK_EN
                ST_WALK: begin
                    if (advance) begin
                        state_d    = ST_SG;
                        interval_d = INT_BASE;
                        start_d    = 1'b1;
                    end
                end
`endif
                ST_SG: begin
                    if (advance) begin
                        start_d = 1'b1;
                        if (sensor_sync) begin
                            state_d    = ST_SGX;
                            interval_d = INT_EXT;
                        end else begin
                            state_d    = ST_SY;
                            interval_d = INT_YEL;
                        end
                    end
                end
                ST_SGX: begin
                    if (advance) begin
                        state_d    = ST_SY;
                        interval_d = INT_YEL;
                        start_d    = 1'b1;
                    end
                end
                ST_SY: begin
                    if (advance) begin
                        state_d    = ST_MG1;
                        interval_d = INT_BASE;
                        start_d    = 1'b1;
                    end
                end
                default: begin
                    // Unreachable code: restart the sequence from MG1.
                    state_d    = ST_MG1;
                    interval_d = INT_BASE;
                    start_d    = 1'b1;
                end
            endcase
        end
    end

    // Light pattern decoded from the next state so lights change with the state.
    always_comb begin
        lights_d = LT_MAIN_GREEN;
        case (state_d)
            ST_MG1:  lights_d = LT_MAIN_GREEN;
            ST_MG2:  lights_d = LT_MAIN_GREEN;
            ST_MY:   lights_d = LT_MAIN_YELLOW;
`ifdef PED_WALK_EN
            ST_WALK: lights_d = LT_WALK;
`endif
            ST_SG:   lights_d = LT_SIDE_GREEN;
            ST_SGX:  lights_d = LT_SIDE_GREEN;
            ST_SY:   lights_d = LT_SIDE_YELLOW;
            default: lights_d = LT_MAIN_GREEN;
        endcase
    end

    // State and output registers; reset puts MG1 with its timer start pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_MG1;
            interval_q <= INT_BASE;
            start_q    <= 1'b1;
            wr_reset_q <= 1'b0;
            lights_q   <= LT_MAIN_GREEN;
        end else begin
            state_q    <= state_d;
            interval_q <= interval_d;
            start_q    <= start_d;
            wr_reset_q <= wr_reset_d;
            lights_q   <= lights_d;
        end
    end

    assign wr_reset    = wr_reset_q;
    assign interval    = interval_q;
    assign start_timer = start_q;
    assign lights      = lights_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_traffic_fsm.sv
// Bench for traffic_fsm: reset check, a vector table, hand-written corner
// sequences, then randomized stimulus against a name-based reference model.
module tb_traffic_fsm;

`ifdef PED_WALK_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic       clock = 1'b0;
  logic       reset_n;
  logic       sensor_sync, wr, prog_sync, expired;
  logic       wr_reset, start_timer;
  logic [1:0] interval;
  logic [6:0] lights;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  traffic_fsm dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .sensor_sync (sensor_sync),
    .wr          (wr),
    .prog_sync   (prog_sync),
    .expired     (expired),
    .wr_reset    (wr_reset),
    .interval    (interval),
    .start_timer (start_timer),
    .lights      (lights),
    .state_dbg_o (state_dbg)
  );

  int n_vec = 0;
  int n_bad = 0;

  // ---------------- scoreboard check ----------------
  task automatic chk(input string name, input logic [6:0] el, input logic [1:0] ei,
                     input logic es, input logic ew);
    n_vec++;
    if (lights !== el || interval !== ei || start_timer !== es || wr_reset !== ew) begin
      n_bad++;
      $display("FAIL %s: got lights=%h interval=%b start=%b wr_reset=%b, expected lights=%h interval=%b start=%b wr_reset=%b",
               name, lights, interval, start_timer, wr_reset, el, ei, es, ew);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs are held across the next rising edge; outputs sampled 1ns later.
  task automatic apply(input logic p, input logic s, input logic w, input logic e);
    prog_sync = p; sensor_sync = s; wr = w; expired = e;
    @(posedge clock);
    #1;
  endtask

  // Clear the pending start pulse, then deliver one expiry.
  task automatic advance(input logic s, input logic w);
    apply(0, 0, 0, 0);
    apply(0, s, w, 1);
  endtask

  task automatic do_reset();
    prog_sync = 0; sensor_sync = 0; wr = 0; expired = 0;
    reset_n = 1'b0;
    #20;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Tracks the controller by phase name; lights come from a name-indexed table.
  string      m_st;
  logic       m_start, m_wrr;
  logic [1:0] m_int;
  logic [6:0] light_tab[string];

  task automatic model_reset();
    m_st = "MG1"; m_start = 1; m_int = 2'b00; m_wrr = 0;
  endtask

  task automatic model_step(input logic p, input logic s, input logic w, input logic e);
    m_wrr = 0;
    if (p) begin
      m_st = "MG1"; m_int = 2'b00; m_start = 1;
    end else if (e && !m_start) begin
      m_start = 1;
      if (m_st == "MG1")       begin m_st = "MG2"; m_int = s ? 2'b01 : 2'b00; end
      else if (m_st == "MG2")  begin m_st = "MY";  m_int = 2'b10; end
      else if (m_st == "MY")   begin
        if (PED && w) begin m_st = "WALK"; m_int = 2'b01; m_wrr = 1; end
        else          begin m_st = "SG";   m_int = 2'b00; end
      end
      else if (m_st == "WALK") begin m_st = "SG";  m_int = 2'b00; end
      else if (m_st == "SG")   begin m_st = s ? "SGX" : "SY"; m_int = s ? 2'b01 : 2'b10; end
      else if (m_st == "SGX")  begin m_st = "SY";  m_int = 2'b10; end
      else                     begin m_st = "MG1"; m_int = 2'b00; end
    end else begin
      m_start = 0;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       p, s, w, e;
    logic [6:0] l;
    logic [1:0] i;
    logic       st, wrr;
  } vec_t;

  vec_t tbl[22];

  initial begin
    light_tab["MG1"] = 7'h18; light_tab["MG2"] = 7'h18; light_tab["MY"] = 7'h28;
    light_tab["WALK"] = 7'h49; light_tab["SG"] = 7'h42; light_tab["SGX"] = 7'h42;
    light_tab["SY"] = 7'h44;

    //            p  s  w  e  lights  int    st wrr
    tbl[0]  = '{0, 0, 0, 0, 7'h18, 2'b00, 0, 0}; // MG1 timer started
    tbl[1]  = '{0, 0, 0, 1, 7'h18, 2'b00, 1, 0}; // -> MG2 (base)
    tbl[2]  = '{0, 0, 0, 1, 7'h18, 2'b00, 0, 0}; // expired ignored on entry
    tbl[3]  = '{0, 0, 0, 1, 7'h28, 2'b10, 1, 0}; // -> MY
    tbl[4]  = '{0, 0, 0, 0, 7'h28, 2'b10, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 7'h42, 2'b00, 1, 0}; // -> SG
    tbl[6]  = '{0, 0, 0, 0, 7'h42, 2'b00, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 7'h44, 2'b10, 1, 0}; // -> SY
    tbl[8]  = '{0, 0, 0, 0, 7'h44, 2'b10, 0, 0};
    tbl[9]  = '{0, 0, 0, 1, 7'h18, 2'b00, 1, 0}; // -> MG1
    tbl[10] = '{0, 0, 0, 0, 7'h18, 2'b00, 0, 0};
    tbl[11] = '{0, 1, 0, 1, 7'h18, 2'b01, 1, 0}; // -> MG2 extended
    tbl[12] = '{0, 0, 0, 0, 7'h18, 2'b01, 0, 0};
    tbl[13] = '{0, 0, 0, 1, 7'h28, 2'b10, 1, 0}; // -> MY
    tbl[14] = '{0, 0, 0, 0, 7'h28, 2'b10, 0, 0};
`ifdef PED_WALK_EN
    tbl[15] = '{0, 0, 1, 1, 7'h49, 2'b01, 1, 1}; // -> WALK
    tbl[16] = '{0, 0, 0, 0, 7'h49, 2'b01, 0, 0};
    tbl[17] = '{0, 1, 0, 1, 7'h42, 2'b00, 1, 0}; // -> SG, sensor irrelevant
    tbl[18] = '{0, 0, 0, 0, 7'h42, 2'b00, 0, 0};
`else
    tbl[15] = '{0, 0, 1, 1, 7'h42, 2'b00, 1, 0}; // wr ignored -> SG
    tbl[16] = '{0, 0, 0, 0, 7'h42, 2'b00, 0, 0};
    tbl[17] = '{0, 1, 0, 1, 7'h42, 2'b01, 1, 0}; // -> SGX
    tbl[18] = '{0, 0, 0, 0, 7'h42, 2'b01, 0, 0};
`endif
    tbl[19] = '{1, 0, 0, 1, 7'h18, 2'b00, 1, 0}; // prog beats expired
    tbl[20] = '{1, 0, 0, 0, 7'h18, 2'b00, 1, 0}; // prog held: pulse repeats
    tbl[21] = '{0, 0, 0, 0, 7'h18, 2'b00, 0, 0};
  end

  // ---------------- test sequence ----------------
  initial begin
    prog_sync = 0; sensor_sync = 0; wr = 0; expired = 0;
    reset_n = 1'b0;
    #100;
    chk("reset", 7'h18, 2'b00, 1, 0);
    reset_n = 1'b1;

    for (int k = 0; k < 22; k++) begin
      apply(tbl[k].p, tbl[k].s, tbl[k].w, tbl[k].e);
      chk($sformatf("vec%0d", k), tbl[k].l, tbl[k].i, tbl[k].st, tbl[k].wrr);
    end

    // SG extension by sensor, then prog in SY.
    do_reset();
    advance(0, 0); advance(0, 0); advance(0, 0);
    chk("to_sg", 7'h42, 2'b00, 1, 0);
    advance(1, 0);
    chk("sgx_entry", 7'h42, 2'b01, 1, 0);
    apply(0, 0, 0, 0);
    chk("sgx_hold", 7'h42, 2'b01, 0, 0);
    advance(0, 0);
    chk("sy_entry", 7'h44, 2'b10, 1, 0);
    apply(0, 0, 0, 0);
    apply(0, 0, 0, 0);
    chk("sy_hold", 7'h44, 2'b10, 0, 0);
    apply(1, 0, 0, 0);
    chk("prog_in_sy", 7'h18, 2'b00, 1, 0);

    // Walk request at MY exit, then prog during the following phase.
    do_reset();
    advance(0, 0); advance(0, 0);
    advance(0, 1);
    if (PED) chk("walk_entry", 7'h49, 2'b01, 1, 1);
    else     chk("no_walk",    7'h42, 2'b00, 1, 0);
    apply(0, 0, 1, 0);
    if (PED) chk("walk_hold", 7'h49, 2'b01, 0, 0);
    else     chk("sg_hold",   7'h42, 2'b00, 0, 0);
    apply(1, 0, 1, 1);
    chk("prog_in_walk", 7'h18, 2'b00, 1, 0);

    // Asynchronous reset in the middle of SG, between clock edges.
    do_reset();
    advance(0, 0); advance(0, 0); advance(0, 0);
    apply(0, 0, 0, 0);
    chk("sg_before_rst", 7'h42, 2'b00, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 7'h18, 2'b00, 1, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Randomized stimulus against the reference model.
    do_reset();
    model_reset();
    for (int k = 0; k < 1500; k++) begin
      logic p, s, w, e;
      p = ($urandom_range(0, 24) == 0);
      s = $urandom_range(0, 1);
      w = $urandom_range(0, 1);
      e = ($urandom_range(0, 3) != 0);
      apply(p, s, w, e);
      model_step(p, s, w, e);
      chk($sformatf("rand%0d_%s", k, m_st), light_tab[m_st], m_int, m_start, m_wrr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
